// File: rtl/run_controller_if.sv
// Control bus between the run controller and whoever drives it (bench or top level).
// The controller side uses the slave modport; the requester side uses master.
interface run_controller_if;
    logic        start;
    logic        halt_req;
    logic        core_en;
    logic        core_clr;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    modport master (
        output start, halt_req,
        input  core_en, core_clr, done, timeout, cycle_count
    );

    modport slave (
        input  start, halt_req,
        output core_en, core_clr, done, timeout, cycle_count
    );
endinterface

// File: rtl/run_controller.sv
// Run sequencer for the datapath: clear pulse, optional hold, bounded run, done.
// All outputs are registered and decoded from the next state.
module run_controller #(
    parameter int MAX_CYCLES = 4096,
    parameter int CLR_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    run_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(MAX_CYCLES - 1);
    localparam logic [3:0]  CLR_LAST = 4'(CLR_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic        timeout_q, timeout_d;
    logic        core_en_q, core_clr_q, done_q;

    // Next-state and counter update; every entry into CLEAR restarts the run bookkeeping
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = CLEAR;
                    clr_cnt_d     = 4'd0;
                    cycle_count_d = 16'd0;
                    timeout_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (clr_cnt_q >= CLR_LAST) begin
                    state_d   = bus.start ? HOLD : RUN;
                    clr_cnt_d = 4'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (bus.start) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cycle_count_d = cycle_count_q + 16'd1;
                if (bus.start) begin
                    state_d       = CLEAR;
                    clr_cnt_d     = 4'd0;
                    cycle_count_d = 16'd0;
                    timeout_d     = 1'b0;
                end else if (bus.halt_req) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (cycle_count_q >= LAST_CNT) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d       = CLEAR;
                    clr_cnt_d     = 4'd0;
                    cycle_count_d = 16'd0;
                    timeout_d     = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d       = IDLE;
                clr_cnt_d     = 4'd0;
                cycle_count_d = 16'd0;
                timeout_d     = 1'b0;
            end
        endcase
    end

    // State, counters and Moore outputs registered together so outputs track the new state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            clr_cnt_q     <= 4'd0;
            cycle_count_q <= 16'd0;
            timeout_q     <= 1'b0;
            core_en_q     <= 1'b0;
            core_clr_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            core_en_q     <= (state_d == RUN);
            core_clr_q    <= (state_d == CLEAR);
            done_q        <= (state_d == DONE);
        end
    end

    assign bus.core_en     = core_en_q;
    assign bus.core_clr    = core_clr_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: default instance plus a MAX_CYCLES=8 instance.
module tb_run_controller;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic        timeout;
        logic [15:0] count;
        int          en_cyc;
        int          clr_cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    run_controller_if bus ();
    run_controller_if bus8 ();

    run_controller #(.MAX_CYCLES(4096), .CLR_CYCLES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    run_controller #(.MAX_CYCLES(8), .CLR_CYCLES(2)) dut8 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus8.slave)
    );

    // Exclusivity of core_en against core_clr and done, on both instances
    always @(negedge clk) begin
        checks++;
        if ((bus.core_en && (bus.core_clr || bus.done)) ||
            (bus8.core_en && (bus8.core_clr || bus8.done))) begin
            errors++;
            $display("FAIL exclusive: en=%b clr=%b done=%b en8=%b clr8=%b done8=%b required en never with clr/done",
                     bus.core_en, bus.core_clr, bus.done, bus8.core_en, bus8.core_clr, bus8.done);
        end
    end

    task automatic run_observe(input int halt_at, input int budget,
                               output int en_cyc, output int clr_cyc, output bit got_done);
        en_cyc   = 0;
        clr_cyc  = 0;
        got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.core_en)  en_cyc++;
            if (bus.core_clr) clr_cyc++;
            bus.halt_req = (halt_at != 0) && bus.core_en && (en_cyc == halt_at);
            @(negedge clk);
        end
        bus.halt_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;  bus.halt_req = 1'b0;
        bus8.start = 1'b0; bus8.halt_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.core_en, bus.core_clr, bus.done, bus.timeout, bus.cycle_count} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0",
                     {bus.core_en, bus.core_clr, bus.done, bus.timeout, bus.cycle_count});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.core_en, bus.core_clr, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_release: got %b required 000", {bus.core_en, bus.core_clr, bus.done});
        end
        reset = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.core_clr !== 1'b1) begin
            errors++;
            $display("FAIL release_with_start: core_clr=%b required 1", bus.core_clr);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_halt_run();
        int en, clr; bit got; exp_t e;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.core_clr !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: core_clr=%b required 1", bus.core_clr);
        end
        exp_q.push_back('{1'b0, 16'd10, 10, 2});
        run_observe(10, 100, en, clr, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || {bus.timeout, bus.cycle_count} !== {e.timeout, e.count}) begin
            errors++;
            $display("FAIL halt_result: done=%b timeout=%b count=%0d required 1 %b %0d",
                     got, bus.timeout, bus.cycle_count, e.timeout, e.count);
        end
        checks++;
        if (en != e.en_cyc || clr != e.clr_cyc) begin
            errors++;
            $display("FAIL halt_cycles: en=%0d clr=%0d required %0d %0d", en, clr, e.en_cyc, e.clr_cyc);
        end
    endtask

    task automatic test_held_start();
        int en, clr; bit got; exp_t e;
        logic [2:0] want;
        bus.start = 1'b1;
        bus.halt_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            want = (i < 2) ? 3'b100 : 3'b000;
            checks++;
            if ({bus.core_clr, bus.core_en, bus.done} !== want) begin
                errors++;
                $display("FAIL held_start[%0d]: clr/en/done=%b required %b", i,
                         {bus.core_clr, bus.core_en, bus.done}, want);
            end
        end
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.core_en !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_latency: core_en=%b required 1", bus.core_en);
        end
        exp_q.push_back('{1'b0, 16'd3, 3, 0});
        run_observe(3, 100, en, clr, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || bus.cycle_count !== e.count || en != e.en_cyc || clr != e.clr_cyc) begin
            errors++;
            $display("FAIL held_run: done=%b count=%0d en=%0d clr=%0d required 1 %0d %0d %0d",
                     got, bus.cycle_count, en, clr, e.count, e.en_cyc, e.clr_cyc);
        end
    endtask

    task automatic test_timeout();
        int en, clr; bit got; exp_t e;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_q.push_back('{1'b1, 16'd4096, 4096, 2});
        run_observe(0, 5000, en, clr, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || {bus.timeout, bus.cycle_count} !== {e.timeout, e.count} || en != e.en_cyc) begin
            errors++;
            $display("FAIL timeout_result: done=%b timeout=%b count=%0d en=%0d required 1 %b %0d %0d",
                     got, bus.timeout, bus.cycle_count, en, e.timeout, e.count, e.en_cyc);
        end
        bus.halt_req = 1'b1;
        repeat (5) @(negedge clk);
        bus.halt_req = 1'b0;
        checks++;
        if ({bus.done, bus.timeout, bus.cycle_count} !== {1'b1, 1'b1, 16'd4096}) begin
            errors++;
            $display("FAIL done_frozen: done=%b timeout=%b count=%0d required 1 1 4096",
                     bus.done, bus.timeout, bus.cycle_count);
        end
    endtask

    task automatic test_restart();
        int en, clr; bit got; exp_t e;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.core_clr, bus.cycle_count} !== {1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL restart_from_done: done=%b clr=%b count=%0d required 0 1 0",
                     bus.done, bus.core_clr, bus.cycle_count);
        end
        en = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.core_en) en++;
            if (en == 4) break;
            @(negedge clk);
        end
        checks++;
        if (en != 4) begin
            errors++;
            $display("FAIL restart_reach_run: en=%0d required 4", en);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.core_clr, bus.core_en, bus.cycle_count} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL restart_from_run: done=%b clr=%b en=%b count=%0d required 0 1 0 0",
                     bus.done, bus.core_clr, bus.core_en, bus.cycle_count);
        end
        exp_q.push_back('{1'b0, 16'd5, 5, 2});
        run_observe(5, 100, en, clr, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || bus.cycle_count !== e.count || en != e.en_cyc || clr != e.clr_cyc) begin
            errors++;
            $display("FAIL restart_run: done=%b count=%0d en=%0d clr=%0d required 1 %0d %0d %0d",
                     got, bus.cycle_count, en, clr, e.count, e.en_cyc, e.clr_cyc);
        end
    endtask

    task automatic test_coincide();
        int en; bit got; exp_t e;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        exp_q.push_back('{1'b0, 16'd8, 8, 2});
        en = 0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus8.done) begin
                got = 1'b1;
                break;
            end
            if (bus8.core_en) en++;
            bus8.halt_req = bus8.core_en && (en == 8);
            @(negedge clk);
        end
        bus8.halt_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || {bus8.timeout, bus8.cycle_count} !== {e.timeout, e.count} || en != e.en_cyc) begin
            errors++;
            $display("FAIL coincide: done=%b timeout=%b count=%0d en=%0d required 1 %b %0d %0d",
                     got, bus8.timeout, bus8.cycle_count, en, e.timeout, e.count, e.en_cyc);
        end
    endtask

    task automatic test_mid_run_reset();
        int en;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        en = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.core_en) en++;
            if (en == 7) break;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.core_en, bus.core_clr, bus.done, bus.cycle_count} !== {3'b000, 16'd0} || en != 7) begin
            errors++;
            $display("FAIL mid_run_reset: en=%b clr=%b done=%b count=%0d runcyc=%0d required 0 0 0 0 7",
                     bus.core_en, bus.core_clr, bus.done, bus.cycle_count, en);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.core_en, bus.core_clr, bus.done, bus.timeout, bus.cycle_count} !== 20'h0) begin
            errors++;
            $display("FAIL idle_after_mid_reset: got %h required 0",
                     {bus.core_en, bus.core_clr, bus.done, bus.timeout, bus.cycle_count});
        end
    endtask

    initial begin
        test_reset();
        test_halt_run();
        test_held_start();
        test_timeout();
        test_restart();
        test_coincide();
        test_mid_run_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Parameters
REQ-001 MAX_CYCLES, default 4096, RUN-cycle budget before forced stop; legal range 1..65535.
REQ-002 CLR_CYCLES, default 2, length of the datapath clear pulse in cycles; legal range 1..15.

Interface
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, regardless of clk.
REQ-005 start  input  1  testbench start request, level-sensitive.
REQ-006 halt_req  input  1  halt decode from control_decoder; qualified only while core_en=1.
REQ-007 core_en  output  1  enables PC update, register-file write and memory write in the datapath.
REQ-008 core_clr  output  1  synchronous clear for PC, register file and data memory control.
REQ-009 done  output  1  program finished, by halt or by timeout.
REQ-010 timeout  output  1  run ended on the MAX_CYCLES budget rather than on halt.
REQ-011 cycle_count  output  16  number of cycles core_en has been high in the current run.

Function
REQ-012 States: IDLE, CLEAR, HOLD, RUN, DONE; all outputs registered, Moore-decoded from state plus counters.
REQ-013 IDLE: core_en=0, core_clr=0, done=0; start=1 -> CLEAR on next edge.
REQ-014 CLEAR: core_clr=1 for exactly CLR_CYCLES consecutive cycles.
REQ-015 CLEAR: cycle_count and timeout are set to 0 on entry.
REQ-016 CLEAR exit: start=1 on the last CLEAR cycle -> HOLD; start=0 -> RUN.
REQ-017 HOLD: core_en=0, core_clr=0; stay while start=1; start=0 -> RUN on next edge.
REQ-018 RUN: core_en=1.
REQ-019 RUN: each RUN cycle increments cycle_count by 1, including the cycle that exits RUN.
REQ-020 RUN priority, highest first: start=1 -> CLEAR (restart, done stays 0); halt_req=1 -> DONE with timeout=0; cycle_count=MAX_CYCLES-1 -> DONE with timeout=1.
REQ-021 On timeout exit, core_en has been high for exactly MAX_CYCLES cycles and cycle_count=MAX_CYCLES.
REQ-022 halt_req and the budget limit in the same cycle: halt wins, timeout=0.
REQ-023 DONE: done=1 and core_en=0; cycle_count and timeout frozen; done held indefinitely.
REQ-024 DONE exit: start=1 -> CLEAR; done falls on the same edge the state enters CLEAR.
REQ-025 halt_req is ignored in IDLE, CLEAR, HOLD and DONE.
REQ-026 cycle_count never wraps: the MAX_CYCLES limit guarantees termination before overflow.
REQ-027 core_en and core_clr are never high in the same cycle.
REQ-028 done and core_en are never high in the same cycle.
REQ-029 Latency: start rising in IDLE -> core_clr=1 one cycle later.
REQ-030 Latency: start falling in HOLD -> core_en=1 one cycle later.
REQ-031 Latency: halt_req in RUN -> done=1 one cycle later.

Reset
REQ-032 reset low -> state IDLE with core_en=0, core_clr=0, done=0, timeout=0, cycle_count=0, asynchronously, from any state including mid-RUN and mid-CLEAR.
REQ-033 On reset release, the first state change occurs on the first rising clk edge with reset high; start already high at release -> CLEAR on that edge.
REQ-034 Internal CLEAR-length counter resets to 0.

Verification
REQ-035 Mid-run reset: reset low during RUN cycle 7 -> core_en=0 and cycle_count=0 before the next edge; IDLE after release.
REQ-036 Halt run: start high 1 cycle, halt_req at RUN cycle 10 -> core_clr high 2 cycles, core_en high 10 cycles, then done=1, timeout=0, cycle_count=10.
REQ-037 Held start: start held 5 cycles -> 2 CLEAR cycles, then HOLD until start falls; core_en=1 on the edge after the fall.
REQ-038 Timeout: no halt_req -> done=1, timeout=1 and cycle_count=4096 after exactly 4096 core_en cycles.
REQ-039 Coincidence: MAX_CYCLES=8 with halt_req on RUN cycle 8 -> done=1, timeout=0, cycle_count=8.
REQ-040 Restart: start pulsed while in DONE -> done=0 and core_clr=1 next cycle, cycle_count=0; start pulsed in RUN -> CLEAR with no done pulse.
